// File: rtl/instruction_encoder_if.sv
// -----------------------------------------------------------------------------
// instruction_encoder_if
// Groups the request fields, the flush control and the instruction-memory write
// port of instruction_encoder.
//   master : request producer; drives req_* and flush, observes everything else
//   slave  : the encoder; drives req_ready and the memory/status outputs
// -----------------------------------------------------------------------------
interface instruction_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_type;
    logic [3:0]            req_cond;
    logic [3:0]            req_opcode;
    logic                  req_s;
    logic                  req_imm;
    logic                  req_u;
    logic                  req_b;
    logic [3:0]            req_rn;
    logic [3:0]            req_rd;
    logic [11:0]           req_operand2;
    logic                  req_link;
    logic [23:0]           req_offset;
    logic                  flush;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wr_data;
    logic [ADDR_WIDTH-2:0] word_count;
    logic                  done;
    logic                  overflow;

    modport master (
        output req_valid, req_type, req_cond, req_opcode, req_s, req_imm,
               req_u, req_b, req_rn, req_rd, req_operand2, req_link,
               req_offset, flush,
        input  req_ready, mem_wr_en, mem_addr, mem_wr_data, word_count,
               done, overflow
    );

    modport slave (
        input  req_valid, req_type, req_cond, req_opcode, req_s, req_imm,
               req_u, req_b, req_rn, req_rd, req_operand2, req_link,
               req_offset, flush,
        output req_ready, mem_wr_en, mem_addr, mem_wr_data, word_count,
               done, overflow
    );
endinterface

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Packs decoded instruction fields into 32-bit ARM-format words and writes them
// to instruction memory at an auto-incrementing, word-aligned byte address.
// A flush pulse pads the stream with NOP_PAD all-zero words.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : instruction_encoder_if.slave
//            req_* / req_valid / req_ready : request handshake and fields
//            flush                         : start NOP padding
//            mem_wr_en/mem_addr/mem_wr_data: registered memory write port
//            word_count                    : words written since reset
//            done                          : pulse with the last pad write
//            overflow                      : sticky, request seen while FULL
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting requests; flush starts padding
// PAD   | emitting NOPs, pad_cnt_q counts the ones still to issue
// FULL  | last word address written; only reset leaves
// -----------------------------------------------------------------------------
module instruction_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int NOP_PAD    = 4
) (
    input logic                  clk,
    input logic                  reset,
    instruction_encoder_if.slave bus
);
    localparam int PTR_W = ADDR_WIDTH - 2;
    localparam int CNT_W = ADDR_WIDTH - 1;
    localparam int PAD_W = (NOP_PAD > 1) ? $clog2(NOP_PAD + 1) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = '1;
    // The first NOP is issued on the flush edge itself, so PAD starts one short.
    localparam logic [PAD_W-1:0] PAD_INIT = PAD_W'((NOP_PAD > 0) ? NOP_PAD - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAD  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PAD_W-1:0]        pad_cnt_q, pad_cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;

    logic                    req_ready_c;
    logic                    issue;
    logic                    issue_pad;
    logic [31:0]             issue_word;

    logic [31:0]             enc_word;
    logic                    dp_s;
    logic [3:0]              dp_rn;
    logic [3:0]              dp_rd;

    // Field packing
    always_comb begin
        enc_word = 32'h0000_0000;
        dp_s     = bus.req_s;
        dp_rn    = bus.req_rn;
        dp_rd    = bus.req_rd;

        // TST/TEQ/CMP/CMN only set flags: S must be 1 and rd is unused
        if (bus.req_opcode[3:2] == 2'b10) begin
            dp_s  = 1'b1;
            dp_rd = 4'h0;
        end
        // MOV/MVN have no first operand
        if (bus.req_opcode[3:2] == 2'b11 && bus.req_opcode[0]) begin
            dp_rn = 4'h0;
        end

        case (bus.req_type)
            2'b00: enc_word = {bus.req_cond, 2'b00, bus.req_imm, bus.req_opcode,
                               dp_s, dp_rn, dp_rd, bus.req_operand2};
            2'b01: enc_word = {bus.req_cond, 2'b01, bus.req_imm, 1'b1, bus.req_u,
                               bus.req_b, 1'b0, bus.req_s, bus.req_rn, bus.req_rd,
                               bus.req_operand2};
            2'b10: enc_word = {bus.req_cond, 3'b101, bus.req_link, bus.req_offset};
            // NOP ignores cond: the decoder only recognises the all-zero word
            default: enc_word = 32'h0000_0000;
        endcase
    end

    // Next state and registered outputs
    always_comb begin
        state_d     = state_q;
        pad_cnt_d   = pad_cnt_q;
        ptr_d       = ptr_q;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        count_d     = count_q + {{(CNT_W-1){1'b0}}, wr_en_q};
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        req_ready_c = 1'b0;
        issue       = 1'b0;
        issue_pad   = 1'b0;
        issue_word  = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                req_ready_c = !bus.flush;
                if (bus.flush) begin
                    if (NOP_PAD == 0) begin
                        done_d = 1'b1;
                    end else begin
                        issue     = 1'b1;
                        issue_pad = 1'b1;
                        pad_cnt_d = PAD_INIT;
                        state_d   = ST_PAD;
                        if (NOP_PAD == 1) begin
                            done_d = 1'b1;
                        end
                    end
                end else if (bus.req_valid) begin
                    issue      = 1'b1;
                    issue_word = enc_word;
                end
            end

            ST_PAD: begin
                // Stay in PAD through the cycle of the last NOP write
                if (pad_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    issue     = 1'b1;
                    issue_pad = 1'b1;
                    pad_cnt_d = pad_cnt_q - PAD_W'(1);
                    if (pad_cnt_q == PAD_W'(1)) begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_FULL: begin
                if (bus.req_valid) begin
                    overflow_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            wr_en_d = 1'b1;
            addr_d  = {ptr_q, 2'b00};
            data_d  = issue_word;
            ptr_d   = ptr_q + PTR_W'(1);
            // Last address: go FULL on the same edge; a cut-short flush still
            // reports done with its final (this) write.
            if (ptr_q == LAST_PTR) begin
                state_d = ST_FULL;
                if (issue_pad) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pad_cnt_q  <= '0;
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_cnt_q  <= pad_cnt_d;
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = data_q;
    assign bus.word_count  = count_q;
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder
// Directed cases plus randomized traffic against a cycle-level reference model
// (expected write schedule, fill level, pad window) for instruction_encoder.
// A second, small instance (ADDR_WIDTH=4, NOP_PAD=2) covers FULL/overflow and
// a flush cut short by the end of memory.
// -----------------------------------------------------------------------------
module tb_instruction_encoder;
    localparam int AW    = 8;
    localparam int PAD   = 4;
    localparam int CAP   = 1 << (AW - 2);
    localparam int AW_S  = 4;
    localparam int PAD_S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset_s;

    instruction_encoder_if #(.ADDR_WIDTH(AW))   bus   ();
    instruction_encoder_if #(.ADDR_WIDTH(AW_S)) bus_s ();

    instruction_encoder #(.ADDR_WIDTH(AW), .NOP_PAD(PAD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instruction_encoder #(.ADDR_WIDTH(AW_S), .NOP_PAD(PAD_S)) dut_s (
        .clk   (clk),
        .reset (reset_s),
        .bus   (bus_s)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        s;
        logic        imm;
        logic        u;
        logic        b;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] op2;
        logic        link;
        logic [23:0] offset;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    wr_t exp_q[$];
    int  cyc          = 0;
    int  m_sched      = 0;
    int  m_written    = 0;
    int  m_full_edge  = -1;
    int  pad_busy_end = -1;
    int  done_due     = -1;
    bit  m_ovf        = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_encode(input req_t r);
        logic [31:0] w;
        int s, rn, rd;
        s  = int'(r.s);
        rn = int'(r.rn);
        rd = int'(r.rd);
        w  = 32'h0;
        case (r.typ)
            2'd0: begin
                if (r.opcode >= 4'd8 && r.opcode <= 4'd11) begin
                    s  = 1;
                    rd = 0;
                end
                if (r.opcode == 4'd13 || r.opcode == 4'd15) rn = 0;
                w = (32'(r.cond) << 28) + (32'(r.imm) << 25) + (32'(r.opcode) << 21)
                  + (32'(s) << 20) + (32'(rn) << 16) + (32'(rd) << 12) + 32'(r.op2);
            end
            2'd1: w = (32'(r.cond) << 28) + (32'd1 << 26) + (32'(r.imm) << 25)
                    + (32'd1 << 24) + (32'(r.u) << 23) + (32'(r.b) << 22)
                    + (32'(r.s) << 20) + (32'(r.rn) << 16) + (32'(r.rd) << 12)
                    + 32'(r.op2);
            2'd2: w = (32'(r.cond) << 28) + (32'd5 << 25) + (32'(r.link) << 24)
                    + 32'(r.offset);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic req_t mk(input logic [1:0] typ, input logic [3:0] cond,
                                input logic [3:0] opcode, input logic s, input logic imm,
                                input logic u, input logic b, input logic [3:0] rn,
                                input logic [3:0] rd, input logic [11:0] op2,
                                input logic link, input logic [23:0] offset);
        req_t r;
        r.typ = typ; r.cond = cond; r.opcode = opcode; r.s = s; r.imm = imm;
        r.u = u; r.b = b; r.rn = rn; r.rd = rd; r.op2 = op2; r.link = link;
        r.offset = offset;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.typ    = 2'($urandom_range(0, 3));
        r.cond   = 4'($urandom);
        r.opcode = 4'($urandom);
        r.s      = 1'($urandom);
        r.imm    = 1'($urandom);
        r.u      = 1'($urandom);
        r.b      = 1'($urandom);
        r.rn     = 4'($urandom);
        r.rd     = 4'($urandom);
        r.op2    = 12'($urandom);
        r.link   = 1'($urandom);
        r.offset = 24'($urandom);
        return r;
    endfunction

    function automatic void schedule(input int due, input logic [31:0] data);
        wr_t w;
        w.due  = due;
        w.addr = 32'(4 * m_sched);
        w.data = data;
        exp_q.push_back(w);
        if (m_sched == CAP - 1) m_full_edge = due;
        m_sched++;
    endfunction

    // One clock of the main instance: check the current outputs against the
    // model, apply stimulus, check req_ready, then advance the model on the edge.
    task automatic step(input req_t r, input bit valid, input bit fl, input bit rst);
        bit exp_wr, full_now, idle, exp_ready, acc;
        int n;
        @(negedge clk);
        exp_wr = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("wr_en", 32'(bus.mem_wr_en), 32'(exp_wr));
        if (exp_wr) begin
            chk("addr", 32'(bus.mem_addr), exp_q[0].addr);
            chk("data", bus.mem_wr_data, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        chk("word_count", 32'(bus.word_count), 32'(m_written));
        if (exp_wr) m_written++;
        chk("done", 32'(bus.done), 32'(done_due == cyc));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));

        bus.req_valid    = valid;
        bus.flush        = fl;
        reset            = rst;
        bus.req_type     = r.typ;
        bus.req_cond     = r.cond;
        bus.req_opcode   = r.opcode;
        bus.req_s        = r.s;
        bus.req_imm      = r.imm;
        bus.req_u        = r.u;
        bus.req_b        = r.b;
        bus.req_rn       = r.rn;
        bus.req_rd       = r.rd;
        bus.req_operand2 = r.op2;
        bus.req_link     = r.link;
        bus.req_offset   = r.offset;
        #1;
        full_now  = (m_full_edge >= 0) && (cyc >= m_full_edge);
        idle      = !full_now && (cyc > pad_busy_end);
        exp_ready = idle && !fl;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        acc = valid && exp_ready;

        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_sched      = 0;
            m_written    = 0;
            m_full_edge  = -1;
            pad_busy_end = -1;
            done_due     = -1;
            m_ovf        = 1'b0;
        end else begin
            if (full_now && valid) m_ovf = 1'b1;
            if (acc) begin
                schedule(cyc, ref_encode(r));
            end else if (idle && fl) begin
                n = 0;
                for (int k = 0; k < PAD; k++) begin
                    if (m_sched < CAP) begin
                        schedule(cyc + k, 32'h0);
                        n++;
                    end
                end
                pad_busy_end = cyc + PAD - 1;
                done_due     = cyc + n - 1;
            end
        end
        #1;
    endtask

    task automatic step_s(input bit valid, input bit fl, input bit rst);
        @(negedge clk);
        bus_s.req_valid = valid;
        bus_s.flush     = fl;
        reset_s         = rst;
        @(posedge clk);
        #1;
    endtask

    req_t idle_r, r_add, r_cmp, r_ldrb, r_str, r_br, rr;
    bit   v, f, rs;

    initial begin
        idle_r = mk(2'd0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 12'h000, 0, 24'h0);
        r_add  = mk(2'd0, 4'hE, 4'b0100, 0, 1, 0, 0, 4'd1, 4'd2, 12'h005, 0, 24'h0);
        r_cmp  = mk(2'd0, 4'hE, 4'b1010, 0, 0, 0, 0, 4'd3, 4'd5, 12'h004, 0, 24'h0);
        r_ldrb = mk(2'd1, 4'hE, 4'h0, 1, 0, 1, 1, 4'd0, 4'd1, 12'h000, 0, 24'h0);
        r_str  = mk(2'd1, 4'hE, 4'h0, 0, 0, 1, 0, 4'd0, 4'd2, 12'h004, 0, 24'h0);
        r_br   = mk(2'd2, 4'hE, 4'h0, 0, 0, 0, 0, 4'd0, 4'd0, 12'h000, 0, 24'hFFFFFE);

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        reset_s             = 1'b1;
        bus_s.req_valid     = 1'b0;
        bus_s.flush         = 1'b0;
        bus_s.req_type      = 2'd0;
        bus_s.req_cond      = 4'hE;
        bus_s.req_opcode    = 4'b0100;
        bus_s.req_s         = 1'b0;
        bus_s.req_imm       = 1'b1;
        bus_s.req_u         = 1'b0;
        bus_s.req_b         = 1'b0;
        bus_s.req_rn        = 4'd1;
        bus_s.req_rd        = 4'd2;
        bus_s.req_operand2  = 12'h005;
        bus_s.req_link      = 1'b0;
        bus_s.req_offset    = 24'h0;
        @(posedge clk);
        @(posedge clk);
        #1;

        chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_count", 32'(bus.word_count), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);

        step(r_add, 1, 0, 0);
        chk("add_en", 32'(bus.mem_wr_en), 32'd1);
        chk("add_addr", 32'(bus.mem_addr), 32'h00);
        chk("add_data", bus.mem_wr_data, 32'hE2812005);
        step(r_cmp, 1, 0, 0);
        chk("cmp_addr", 32'(bus.mem_addr), 32'h04);
        chk("cmp_data", bus.mem_wr_data, 32'hE1530004);

        step(idle_r, 0, 0, 1);
        step(r_ldrb, 1, 0, 0);
        chk("ldrb_addr", 32'(bus.mem_addr), 32'h00);
        chk("ldrb_data", bus.mem_wr_data, 32'hE5D01000);
        step(r_str, 1, 0, 0);
        chk("str_en", 32'(bus.mem_wr_en), 32'd1);
        chk("str_addr", 32'(bus.mem_addr), 32'h04);
        chk("str_data", bus.mem_wr_data, 32'hE5802004);
        step(r_br, 1, 0, 0);
        chk("br_addr", 32'(bus.mem_addr), 32'h08);
        chk("br_data", bus.mem_wr_data, 32'hEAFFFFFE);

        step(idle_r, 0, 0, 1);
        step(r_add, 1, 0, 0);
        step(idle_r, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step(idle_r, 0, 0, 0);
            chk("pad_en", 32'(bus.mem_wr_en), 32'd1);
            chk("pad_addr", 32'(bus.mem_addr), 32'(4 + 4 * k));
            chk("pad_data", bus.mem_wr_data, 32'h0);
            chk("pad_done", 32'(bus.done), 32'(k == 3));
            chk("pad_ready", 32'(bus.req_ready), 32'd0);
        end
        step(idle_r, 0, 0, 0);
        chk("pad_count", 32'(bus.word_count), 32'd5);
        chk("pad_idle_en", 32'(bus.mem_wr_en), 32'd0);
        chk("pad_ready_back", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            rr = rand_req();
            v  = ($urandom_range(0, 99) < 70);
            f  = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 119) == 0);
            step(rr, v, f, rs);
        end
        step(idle_r, 0, 0, 0);

        // small instance: FULL, overflow, truncated flush
        step_s(0, 0, 1);
        chk("s_rst_ready", 32'(bus_s.req_ready), 32'd1);
        chk("s_rst_ovf", 32'(bus_s.overflow), 32'd0);
        for (int k = 0; k < 4; k++) step_s(1, 0, 0);
        chk("s_full_en", 32'(bus_s.mem_wr_en), 32'd1);
        chk("s_full_addr", 32'(bus_s.mem_addr), 32'h0C);
        chk("s_full_ready", 32'(bus_s.req_ready), 32'd0);
        step_s(1, 0, 0);
        chk("s_ovf_set", 32'(bus_s.overflow), 32'd1);
        chk("s_ovf_count", 32'(bus_s.word_count), 32'd4);
        step_s(0, 1, 0);
        chk("s_ovf_sticky", 32'(bus_s.overflow), 32'd1);
        chk("s_full_no_wr", 32'(bus_s.mem_wr_en), 32'd0);
        chk("s_full_no_done", 32'(bus_s.done), 32'd0);
        step_s(0, 0, 1);
        chk("s_ovf_clear", 32'(bus_s.overflow), 32'd0);
        chk("s_ready_back", 32'(bus_s.req_ready), 32'd1);
        chk("s_count_clear", 32'(bus_s.word_count), 32'd0);

        for (int k = 0; k < 3; k++) step_s(1, 0, 0);
        step_s(0, 1, 0);
        chk("s_cut_en", 32'(bus_s.mem_wr_en), 32'd1);
        chk("s_cut_addr", 32'(bus_s.mem_addr), 32'h0C);
        chk("s_cut_data", bus_s.mem_wr_data, 32'h0);
        chk("s_cut_done", 32'(bus_s.done), 32'd1);
        step_s(0, 0, 0);
        chk("s_cut_no_wr", 32'(bus_s.mem_wr_en), 32'd0);
        chk("s_cut_done_off", 32'(bus_s.done), 32'd0);
        chk("s_cut_ready", 32'(bus_s.req_ready), 32'd0);
        chk("s_cut_count", 32'(bus_s.word_count), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential encoder that packs decoded instruction fields into 32-bit ARM-format instruction words. It is the mirror of the control unit's decode path. Each accepted request is written into instruction memory at a word-aligned byte address that auto-increments. The block is used to load test programs and to generate instruction streams for the datapath, and it can pad the stream with NOPs to drain the pipeline.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width; capacity CAP = 2^(ADDR_WIDTH-2) words
- NOP_PAD, 4, number of NOP words written per flush

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_type  in  2  00 data-processing, 01 load/store, 10 branch, 11 NOP
- req_cond  in  4  condition field [31:28]
- req_opcode  in  4  data-processing opcode [24:21]
- req_s  in  1  S bit (data-processing) / L bit (load/store), bit 20
- req_imm  in  1  I bit, bit 25, passed verbatim
- req_u, req_b  in  1 each  load/store U (bit 23) and B (bit 22)
- req_rn, req_rd  in  4 each  base and destination registers
- req_operand2  in  12  shifter operand / offset [11:0]
- req_link  in  1  branch L bit, bit 24
- req_offset  in  24  branch offset [23:0]
- flush  in  1  single-cycle pulse; start NOP padding
- mem_wr_en  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_WIDTH  byte address, always a multiple of 4
- mem_wr_data  out  32  encoded word
- word_count  out  ADDR_WIDTH-1  words written since reset
- done  out  1  one-cycle pulse when flush padding completes
- overflow  out  1  sticky; request presented while FULL

## Operation
Encoding (a combinational function of the request fields):
- DP: {cond, 00, I, opcode, S, rn, rd, op2}
  - For opcodes 1000–1011 (TST/TEQ/CMP/CMN), S is forced to 1 and rd to 0.
  - For opcodes 1101/1111 (MOV/MVN), rn is forced to 0.
- LS: {cond, 01, I, 1 (P), U, B, 0 (W), L, rn, rd, op2}.
- Branch: {cond, 101, link, offset}.
- NOP: 32'h00000000. req_cond is ignored, because the decoder treats only all-zero as NOP.

State machine: IDLE, PAD, FULL.
- IDLE:
  - req_ready = !flush.
  - An accepted request registers its word for the next-cycle write.
  - flush (which has priority over req_valid) → PAD, with the pad counter loaded with NOP_PAD.
- PAD:
  - req_ready = 0.
  - Writes one NOP per cycle.
  - When the counter reaches 0, pulse done → IDLE.
  - NOP_PAD = 0 → done pulses the cycle after flush, and there are no writes.
- FULL:
  - req_ready = 0 and flush is ignored.
  - req_valid asserted → overflow set; it stays set until reset.
  - Only reset exits FULL.

Write pointer:
- Starts at 0 and advances by 4 per write.
- No wrap-around. The write to byte address 4·(CAP-1) moves the state to FULL at that same edge.
- If FULL is reached during PAD, the remaining pads are dropped and done still pulses in the cycle the last word is written.

Reset: a synchronous reset at any point, including mid-PAD or with a write pending, behaves as follows.
- Aborts all activity: the pending write is discarded and not written.
- Outputs are 0 except req_ready, which is 1.
- State returns to IDLE and the pointer to 0.

## Timing
- Request accepted at edge N → mem_wr_en = 1 with mem_addr/mem_wr_data valid during cycle N+1 (one-cycle latency); word_count increments at edge N+1.
- Throughput is one word per cycle; back-to-back requests give consecutive writes at addresses A, A+4, ….
- All outputs are registered except req_ready, which is combinational from state and flush.
- Flush at edge N → NOP writes in cycles N+1 … N+NOP_PAD; done is high in cycle N+NOP_PAD, coincident with the last write; req_ready returns high in cycle N+NOP_PAD+1.
- mem_wr_en is never high for more than one cycle per word; mem_addr holds its last value when idle.

## Test plan
- Reset → mem_wr_en=0, mem_addr=0, word_count=0, done=0, overflow=0, req_ready=1.
- DP ADD, cond E, I=1, opcode 0100, S=0, rn=1, rd=2, op2=0x005 → the following cycle has mem_wr_en=1, mem_addr=0x00, mem_wr_data=0xE2812005.
- CMP, cond E, I=0, opcode 1010, S=0, rn=3, rd=5, op2=0x004 → 0xE1530004 (S forced, rd forced).
- Back-to-back load/store writes in consecutive cycles:
  - LDRB (U=1, B=1, L=1, rn=0, rd=1, op2=0) → 0xE5D01000 @0x00.
  - STR (U=1, B=0, L=0, rn=0, rd=2, op2=0x004) → 0xE5802004 @0x04.
- Branch, cond E, link=0, offset 0xFFFFFE → 0xEAFFFFFE.
- Flush and FULL:
  - One word, then flush with NOP_PAD=4 → zeros written @0x04, 0x08, 0x0C, 0x10; done in the 4th write cycle; word_count=5.
  - ADDR_WIDTH=4: four requests → FULL, req_ready=0; a fifth req_valid → overflow=1; reset → overflow=0, req_ready=1.
